fifo_replay_buf: RTL and testbench

Multi-lane line-buffer FIFO that keeps a sliding window of frames. Entries stay resident until explicitly popped, so the read pointer can be rewound and the same data replayed across passes.
It is the successor to the lane-shared 2-port RF FIFO. It adds full/empty tracking, rdy/ack handshakes on both the write and read sides, an occupancy count, and a pop clamp.
It sits between the input fetch stage and the PE array feeding the accumulator datapath.

---
 rtl/fifo_replay_buf.sv | 149 ++++++++++++++
 tb/tb_fifo_replay_buf.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_replay_buf.sv
// fifo_replay_buf
//   Multi-lane line-buffer FIFO holding a sliding window of frames between the
//   input fetch stage and the PE array. Entries stay resident until popped, so
//   the read pointer can be rewound (i_lastpix) and the same data replayed.
//   One 2-port RAM per lane; all control (pointers, count, handshakes) shared.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_write_rdy        write request        -> o_write_ack (accepted this cycle)
//   i_dupWrite         advance end without writing the RAM (data reuse)
//   i_wdata            InsNum lanes of DWd bits, lane i at [i*DWd +: DWd]
//   i_read_rdy         read request         -> o_read_ack (accepted this cycle)
//   o_rdata, o_rvalid  read data, valid one cycle after o_read_ack
//   i_pop              retire the oldest entry (ignored when empty)
//   i_lastpix          rewind the read pointer to the oldest entry
//   o_full, o_empty    occupancy flags decoded from registered count
//
// Optional build macro FIFOREPLAY_OCC_EN
//   Adds o_count (occupancy) and o_unread (entries between read pointer and
//   end) for downstream prefetch throttling. Undefined: neither port exists.
module fifo_replay_buf #(
  parameter int Size   = 12,
  parameter int DWd    = 16,
  parameter int InsNum = 16,
  parameter int AWd    = $clog2(Size),
  parameter int CWd    = $clog2(Size + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_write_rdy,
  output logic                  o_write_ack,
  input  logic                  i_dupWrite,
  input  logic [InsNum*DWd-1:0] i_wdata,
  input  logic                  i_read_rdy,
  output logic                  o_read_ack,
  output logic [InsNum*DWd-1:0] o_rdata,
  output logic                  o_rvalid,
  input  logic                  i_pop,
  input  logic                  i_lastpix,
  output logic                  o_full,
  output logic                  o_empty
`ifdef FIFOREPLAY_OCC_EN
  ,
  output logic [CWd-1:0]        o_count,
  output logic [CWd-1:0]        o_unread
`endif
);

  logic [AWd-1:0] start_r, end_r, raddr_r;
  logic [CWd-1:0] cnt_r;
  logic           rvalid_r;
  logic           rd_done_r;

  logic           write_ack, read_ack, pop, avail, ptr_ce;
  logic [AWd-1:0] start_inc, end_inc, raddr_inc, raddr_nxt;

  // Wrapping increment; Size need not be a power of two.
  function automatic logic [AWd-1:0] inc(input logic [AWd-1:0] p);
    if (p == AWd'(Size - 1)) return '0;
    return p + AWd'(1);
  endfunction

  assign start_inc = inc(start_r);
  assign end_inc   = inc(end_r);
  assign raddr_inc = inc(raddr_r);

  assign o_full  = (cnt_r == CWd'(Size));
  assign o_empty = (cnt_r == '0);

  // When full, start == end, so raddr == end is ambiguous: it means either
  // "whole window unread" or "whole window already read". rd_done_r tells
  // the two apart.
  assign avail = (raddr_r != end_r) |
                 (o_full & (raddr_r == start_r) & ~rd_done_r);

  // Handshakes are forced low while reset is held so nothing is accepted.
  assign write_ack = ~i_rst & i_write_rdy & ~o_full;
  assign read_ack  = ~i_rst & i_read_rdy & avail;
  assign pop       = ~i_rst & i_pop & ~o_empty;
  assign ptr_ce    = write_ack | read_ack | pop | i_lastpix;

  assign o_write_ack = write_ack;
  assign o_read_ack  = read_ack;
  assign o_rvalid    = rvalid_r;

  // Rewind beats read advance; a pop that retires the entry under raddr
  // drags raddr along so it never points outside the window.
  always_comb begin
    raddr_nxt = raddr_r;
    if (i_lastpix & pop)                   raddr_nxt = start_inc;
    else if (i_lastpix)                    raddr_nxt = start_r;
    else if (read_ack)                     raddr_nxt = raddr_inc;
    else if (pop & (raddr_r == start_r))   raddr_nxt = start_inc;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      start_r   <= '0;
      end_r     <= '0;
      raddr_r   <= '0;
      cnt_r     <= '0;
      rvalid_r  <= 1'b0;
      rd_done_r <= 1'b0;
    end else begin
      rvalid_r <= read_ack;
      if (ptr_ce) begin
        if (write_ack) end_r   <= end_inc;
        if (pop)       start_r <= start_inc;
        raddr_r <= raddr_nxt;
      end
      cnt_r <= cnt_r + CWd'(write_ack) - CWd'(pop);
      if (i_lastpix | pop | write_ack)
        rd_done_r <= 1'b0;
      else if (read_ack & o_full & (raddr_inc == end_r))
        rd_done_r <= 1'b1;
    end
  end

  // ---- RAM stage: write at end_r, registered read of raddr_r (latency 1) ----
  for (genvar g = 0; g < InsNum; g++) begin : g_lane
    logic [DWd-1:0] mem [Size];
    logic [DWd-1:0] rdata_p1;

    always_ff @(posedge i_clk) begin
      if (write_ack & ~i_dupWrite) mem[end_r] <= i_wdata[g*DWd +: DWd];
      if (read_ack)                rdata_p1  <= mem[raddr_r];
    end

    assign o_rdata[g*DWd +: DWd] = rdata_p1;
  end

`ifdef FIFOREPLAY_OCC_EN
  logic [CWd-1:0] unread;

  always_comb begin
    unread = '0;
    if (raddr_r == end_r)
      unread = (o_full & ~rd_done_r) ? CWd'(Size) : '0;
    else if (end_r > raddr_r)
      unread = CWd'(end_r - raddr_r);
    else
      unread = CWd'(Size) - CWd'(raddr_r) + CWd'(end_r);
  end

  assign o_count  = cnt_r;
  assign o_unread = unread;
`endif

endmodule

// File: tb/tb_fifo_replay_buf.sv
module tb_fifo_replay_buf;
  localparam int Size   = 12;
  localparam int DWd    = 16;
  localparam int InsNum = 16;
  localparam int W      = InsNum * DWd;
  localparam int CWd    = $clog2(Size + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         write_rdy = 1'b0;
  logic         write_ack;
  logic         dup_write = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         read_rdy = 1'b0;
  logic         read_ack;
  logic [W-1:0] rdata;
  logic         rvalid;
  logic         pop = 1'b0;
  logic         lastpix = 1'b0;
  logic         full, empty;
`ifdef FIFOREPLAY_OCC_EN
  logic [CWd-1:0] count, unread;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_replay_buf #(.Size(Size), .DWd(DWd), .InsNum(InsNum)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_write_rdy(write_rdy), .o_write_ack(write_ack), .i_dupWrite(dup_write),
    .i_wdata(wdata),
    .i_read_rdy(read_rdy), .o_read_ack(read_ack),
    .o_rdata(rdata), .o_rvalid(rvalid),
    .i_pop(pop), .i_lastpix(lastpix),
    .o_full(full), .o_empty(empty)
`ifdef FIFOREPLAY_OCC_EN
    , .o_count(count), .o_unread(unread)
`endif
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rep(input int v);
    logic [DWd-1:0] x;
    x = v[DWd-1:0];
    return {InsNum{x}};
  endfunction

  // Drive one cycle's inputs just after the rising edge, return at the falling
  // edge so the caller can sample that cycle's outputs.
  task automatic step(input logic rs, input logic w, input logic d,
                      input logic [W-1:0] wd, input logic r, input logic p,
                      input logic lp);
    @(posedge clk);
    #1;
    rst = rs; write_rdy = w; dup_write = d; wdata = wd;
    read_rdy = r; pop = p; lastpix = lp;
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Entries are tracked by absolute sequence number: the window is
  // [popped, written), the read cursor rd is an absolute index, and the RAM
  // address of an index is index % Size.
  int           m_wr = 0, m_pop = 0, m_rd = 0, m_cnt;
  logic [W-1:0] m_mem [Size];
  bit           m_known [Size];
  bit           m_pend_v = 0, m_pend_k = 0;
  logic [W-1:0] m_pend_d = '0;
  bit           e_full, e_empty, e_wack, e_rack, e_pop;
  int           new_pop;

  always @(negedge clk) begin
    if (rst) begin
      m_wr = 0; m_pop = 0; m_rd = 0; m_pend_v = 0;
    end
    m_cnt   = m_wr - m_pop;
    e_full  = (m_cnt == Size);
    e_empty = (m_cnt == 0);
    e_wack  = !rst && write_rdy && !e_full;
    e_rack  = !rst && read_rdy && (m_rd < m_wr);
    e_pop   = !rst && pop && !e_empty;

    chk("m_full", full, e_full);
    chk("m_empty", empty, e_empty);
    chk("m_wack", write_ack, e_wack);
    chk("m_rack", read_ack, e_rack);
    chk("m_rvalid", rvalid, m_pend_v);
    if (m_pend_v && m_pend_k) chk("m_rdata", rdata, m_pend_d);
`ifdef FIFOREPLAY_OCC_EN
    chk("m_count", count, m_cnt);
    chk("m_unread", unread, m_wr - m_rd);
`endif

    m_pend_v = e_rack;
    if (e_rack) begin
      m_pend_d = m_mem[m_rd % Size];
      m_pend_k = m_known[m_rd % Size];
    end
    if (e_wack) begin
      if (!dup_write) begin
        m_mem[m_wr % Size]   = wdata;
        m_known[m_wr % Size] = 1;
      end
      m_wr++;
    end
    new_pop = m_pop + (e_pop ? 1 : 0);
    if (!rst && lastpix)
      m_rd = new_pop;
    else if (e_rack)
      m_rd++;
    else if (e_pop && ((m_rd - m_pop) % Size == 0))
      // cursor sits on the retired slot's address: it moves to the new oldest
      m_rd = new_pop;
    m_pop = new_pop;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] wd;
    int m, pw, pr, pp;

    step(1, 0, 0, '0, 0, 0, 0);
    step(1, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 0, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rvalid", rvalid, 0);

    // fill with data = index
    for (int k = 0; k < Size; k++) begin
      step(0, 1, 0, rep(k), 0, 0, 0);
      chk("fill_ack", write_ack, 1);
    end
    step(0, 1, 0, rep(12), 0, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_blocked", write_ack, 0);

    // read the whole window
    for (int k = 0; k < Size; k++) begin
      step(0, 0, 0, '0, 1, 0, 0);
      chk("rd_ack", read_ack, 1);
      if (k > 0) begin
        chk("rd_valid", rvalid, 1);
        chk("rd_data", rdata, rep(k - 1));
      end
    end
    step(0, 0, 0, '0, 0, 0, 0);
    chk("rd_last_valid", rvalid, 1);
    chk("rd_last_data", rdata, rep(11));
    step(0, 0, 0, '0, 1, 0, 0);
    chk("rd_13_noack", read_ack, 0);
    step(0, 0, 0, '0, 0, 0, 0);
    chk("rd_valid_drop", rvalid, 0);

    // rewind and replay 0,1,2
    step(0, 0, 0, '0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, '0, 1, 0, 0);
      chk("rw_ack", read_ack, 1);
      if (k > 0) chk("rw_data", rdata, rep(k - 1));
    end
    step(0, 0, 0, '0, 0, 0, 0);
    chk("rw_data2", rdata, rep(2));

    // pop 2, then rewind+pop, then one read -> entry 3
    step(0, 0, 0, '0, 0, 1, 0);
    step(0, 0, 0, '0, 0, 1, 0);
    step(0, 0, 0, '0, 0, 1, 1);
    step(0, 0, 0, '0, 1, 0, 0);
    chk("lp_pop_ack", read_ack, 1);
    step(0, 0, 0, '0, 0, 0, 0);
    chk("lp_pop_data", rdata, rep(3));

    // pop on empty is ignored; raddr clamp when pop hits raddr==start
    step(1, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, 0);
    chk("pop_empty", empty, 1);
    for (int k = 0; k < 7; k++) step(0, 1, 0, rep(100 + k), 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 0, '0, 0, 1, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    chk("clamp_ack", read_ack, 1);
    step(0, 0, 0, '0, 0, 0, 0);
    chk("clamp_data", rdata, rep(106));

    // reset mid-stream with 7 entries and a transfer in flight
    step(1, 0, 0, '0, 0, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 1, 0, rep(200 + k), 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    step(1, 1, 0, rep(999), 1, 0, 0);
    chk("mid_rst_wack", write_ack, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    step(0, 0, 0, '0, 0, 0, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_rvalid2", rvalid, 0);

    // duplicate write: advances end, RAM entry 0 keeps 200
    step(0, 1, 1, rep(16'hDEAD), 0, 0, 0);
    chk("dup_ack", write_ack, 1);
    step(0, 0, 0, '0, 1, 0, 0);
    chk("dup_nonempty", empty, 0);
    chk("dup_rack", read_ack, 1);
    step(0, 0, 0, '0, 0, 0, 0);
    chk("dup_data", rdata, rep(200));

    // randomized traffic in write-heavy / read-heavy / pop-heavy phases
    for (int c = 0; c < 4000; c++) begin
      m = (c / 150) % 3;
      pw = (m == 0) ? 80 : (m == 1) ? 20 : 50;
      pr = (m == 0) ? 20 : (m == 1) ? 80 : 50;
      pp = (m == 2) ? 40 : 10;
      for (int i = 0; i < InsNum; i++) wd[i*DWd +: DWd] = DWd'($urandom);
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 99) < pw,
           $urandom_range(0, 9) == 0,
           wd,
           $urandom_range(0, 99) < pr,
           $urandom_range(0, 99) < pp,
           $urandom_range(0, 19) == 0);
    end

    step(0, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
